// File: rtl/grover_sequencer_if.sv
// Handshake and datapath bundle between the Grover sequencer, its user and the
// external invert_mean block. Names carry the sequencer's point of view.
interface grover_sequencer_if;
   logic        i_start;
   logic [2:0]  i_target;
   logic [63:0] i_dm_out;
   logic        o_busy;
   logic        o_done;
   logic [2:0]  o_result_idx;
   logic [7:0]  o_result_amp;
   logic [63:0] o_dm_in;
   logic [63:0] o_amp_out;

   modport master (
      output i_start,
      output i_target,
      output i_dm_out,
      input  o_busy,
      input  o_done,
      input  o_result_idx,
      input  o_result_amp,
      input  o_dm_in,
      input  o_amp_out
   );

   modport slave (
      input  i_start,
      input  i_target,
      input  i_dm_out,
      output o_busy,
      output o_done,
      output o_result_idx,
      output o_result_amp,
      output o_dm_in,
      output o_amp_out
   );
endinterface

// File: rtl/grover_sequencer.sv
// Runs one 3-qubit Grover search: uniform load, ITER oracle/diffusion rounds
// through an external invert_mean block, then an 8-cycle argmax scan.
module grover_sequencer #(
   parameter int unsigned        ITER     = 2,
   parameter logic signed [7:0]  INIT_AMP = 8'sd23
) (
   input logic clk,
   input logic rst,
   grover_sequencer_if.slave bus
);

   localparam bit        SkipRounds = (ITER == 0);
   localparam logic [4:0] IterCount = 5'(ITER);

   typedef enum logic [2:0] {
      StIdle,
      StInit,
      StOracle,
      StDiff,
      StScan,
      StDone
   } state_t;

   state_t            r_state;
   logic signed [7:0] r_amp [8];
   logic [2:0]        r_target;
   logic [3:0]        r_round;
   logic [2:0]        r_scan_k;
   logic signed [7:0] r_best_amp;
   logic [2:0]        r_best_idx;
   logic              r_busy;
   logic              r_done;
   logic [2:0]        r_result_idx;
   logic signed [7:0] r_result_amp;

   logic [63:0]       w_amp_packed;
   logic signed [7:0] w_scan_amp;
   logic              w_take;
   logic signed [7:0] w_next_best_amp;
   logic [2:0]        w_next_best_idx;
   logic [4:0]        w_round_next;
   logic              w_last_round;

   always_comb begin
      w_amp_packed = '0;
      for (int k = 0; k < 8; k++) begin
         w_amp_packed[8*k +: 8] = r_amp[k];
      end
   end

   assign bus.o_amp_out    = w_amp_packed;
   assign bus.o_dm_in      = w_amp_packed;
   assign bus.o_busy       = r_busy;
   assign bus.o_done       = r_done;
   assign bus.o_result_idx = r_result_idx;
   assign bus.o_result_amp = r_result_amp;

   // k=0 always seeds the running best; later entries win only on strict signed >.
   assign w_scan_amp      = r_amp[r_scan_k];
   assign w_take          = (r_scan_k == 3'd0) || (w_scan_amp > r_best_amp);
   assign w_next_best_amp = w_take ? w_scan_amp : r_best_amp;
   assign w_next_best_idx = w_take ? r_scan_k : r_best_idx;

   assign w_round_next = {1'b0, r_round} + 5'd1;
   assign w_last_round = (w_round_next == IterCount);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= StIdle;
         for (int k = 0; k < 8; k++) begin
            r_amp[k] <= '0;
         end
         r_target     <= '0;
         r_round      <= '0;
         r_scan_k     <= '0;
         r_best_amp   <= '0;
         r_best_idx   <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_result_idx <= '0;
         r_result_amp <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            StIdle: begin
               if (bus.i_start) begin
                  r_target <= bus.i_target;
                  r_round  <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= StInit;
               end
            end
            StInit: begin
               for (int k = 0; k < 8; k++) begin
                  r_amp[k] <= INIT_AMP;
               end
               r_scan_k <= '0;
               r_state  <= SkipRounds ? StScan : StOracle;
            end
            StOracle: begin
               r_amp[r_target] <= -r_amp[r_target];
               r_state         <= StDiff;
            end
            StDiff: begin
               for (int k = 0; k < 8; k++) begin
                  r_amp[k] <= $signed(bus.i_dm_out[8*k +: 8]);
               end
               r_round <= w_round_next[3:0];
               if (w_last_round) begin
                  r_scan_k <= '0;
                  r_state  <= StScan;
               end else begin
                  r_state  <= StOracle;
               end
            end
            StScan: begin
               r_best_amp <= w_next_best_amp;
               r_best_idx <= w_next_best_idx;
               r_scan_k   <= r_scan_k + 3'd1;
               if (r_scan_k == 3'd7) begin
                  r_result_amp <= w_next_best_amp;
                  r_result_idx <= w_next_best_idx;
                  r_done       <= 1'b1;
                  r_state      <= StDone;
               end
            end
            StDone: begin
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_grover_sequencer.sv
// Directed and randomized checks of grover_sequencer against an arithmetic
// model of Grover's rounds, with invert_mean modelled behaviourally.
module tb_grover_sequencer;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   grover_sequencer_if bus0 ();
   grover_sequencer_if bus1 ();

   grover_sequencer #(.ITER(2), .INIT_AMP(8'sd23)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   grover_sequencer #(.ITER(0), .INIT_AMP(8'sd23)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int floor4(input int s);
      return (s - (((s % 4) + 4) % 4)) / 4;
   endfunction

   function automatic int wrap8(input int x);
      return (((x + 128) % 256) + 256) % 256 - 128;
   endfunction

   // Reflection about the mean: o_k = floor(sum/4) - i_k, wrapping to 8 bits.
   function automatic logic [63:0] inv_mean(input logic [63:0] v);
      int s;
      int m;
      logic [63:0] r;
      s = 0;
      for (int k = 0; k < 8; k++) s += int'($signed(v[8*k +: 8]));
      m = floor4(s);
      r = '0;
      for (int k = 0; k < 8; k++) r[8*k +: 8] = 8'(m - int'($signed(v[8*k +: 8])));
      return r;
   endfunction

   always_comb begin
      bus0.i_dm_out = '0;
      bus0.i_dm_out = inv_mean(bus0.o_dm_in);
   end

   always_comb begin
      bus1.i_dm_out = '0;
      bus1.i_dm_out = inv_mean(bus1.o_dm_in);
   end

   logic [63:0] m_packed;
   int          m_idx;
   int          m_best;

   task automatic ref_model(input int tgt, input int iters);
      int a[8];
      int s;
      int m;
      for (int k = 0; k < 8; k++) a[k] = 23;
      for (int r = 0; r < iters; r++) begin
         a[tgt] = wrap8(-a[tgt]);
         s = 0;
         for (int k = 0; k < 8; k++) s += a[k];
         m = floor4(s);
         for (int k = 0; k < 8; k++) a[k] = wrap8(m - a[k]);
      end
      m_idx = 0;
      for (int k = 1; k < 8; k++) if (a[k] > a[m_idx]) m_idx = k;
      m_best = a[m_idx];
      m_packed = '0;
      for (int k = 0; k < 8; k++) m_packed[8*k +: 8] = 8'(a[k]);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full search on the ITER=2 instance; optional mid-run and stray-start checks.
   task automatic do_run(input logic [2:0] tgt, input bit mid_chk, input bit extra_starts);
      int          done_cnt;
      int          done_edge;
      logic [63:0] snap_amp;
      logic [2:0]  snap_idx;
      logic [7:0]  snap_ramp;
      done_cnt  = 0;
      done_edge = -1;
      snap_amp  = 'x;
      snap_idx  = 'x;
      snap_ramp = 'x;
      bus0.i_target = tgt;
      bus0.i_start  = 1'b1;
      @(posedge clk);
      #1;
      bus0.i_start  = 1'b0;
      bus0.i_target = 3'($urandom);
      chk("busy_after_start", 64'(bus0.o_busy), 64'd1);
      for (int e = 1; e <= 30; e++) begin
         if (extra_starts && (e == 3 || e == 13 || e == 14)) begin
            bus0.i_start  = 1'b1;
            bus0.i_target = 3'($urandom);
         end
         @(posedge clk);
         #1;
         bus0.i_start = 1'b0;
         chk("dm_in_eq_amp_out", bus0.o_dm_in, bus0.o_amp_out);
         if (mid_chk && e == 3) begin
            ref_model(int'(tgt), 1);
            chk("round1_amps", bus0.o_amp_out, m_packed);
         end
         if (bus0.o_done) begin
            done_cnt++;
            if (done_edge < 0) begin
               done_edge = e;
               snap_amp  = bus0.o_amp_out;
               snap_idx  = bus0.o_result_idx;
               snap_ramp = bus0.o_result_amp;
            end
         end
      end
      ref_model(int'(tgt), 2);
      chk("done_edge", 64'(done_edge), 64'd13);
      chk("done_count", 64'(done_cnt), 64'd1);
      chk("final_amps", snap_amp, m_packed);
      chk("result_idx", 64'(snap_idx), 64'(m_idx));
      chk("result_amp", 64'(snap_ramp), 64'(8'(m_best)));
      chk("result_idx_held", 64'(bus0.o_result_idx), 64'(m_idx));
      chk("busy_idle", 64'(bus0.o_busy), 64'd0);
   endtask

   initial begin
      int done_cnt;
      int done_edge;
      logic [63:0] snap_amp;
      logic [2:0]  snap_idx;
      logic [7:0]  snap_ramp;
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      bus0.i_start = 1'b0;
      bus0.i_target = '0;
      bus1.i_start = 1'b0;
      bus1.i_target = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 64'(bus0.o_busy), 64'd0);
      chk("rst_done", 64'(bus0.o_done), 64'd0);
      chk("rst_amps", bus0.o_amp_out, 64'd0);
      chk("rst_idx", 64'(bus0.o_result_idx), 64'd0);
      chk("rst_amp", 64'(bus0.o_result_amp), 64'd0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Known trajectory for target 5, with round-1 snapshot.
      do_run(3'd5, 1'b1, 1'b0);

      // ITER=0: uniform amplitudes, tie resolves to index 0.
      done_cnt = 0;
      done_edge = -1;
      snap_amp = 'x;
      snap_idx = 'x;
      snap_ramp = 'x;
      bus1.i_target = 3'd3;
      bus1.i_start  = 1'b1;
      @(posedge clk);
      #1;
      bus1.i_start = 1'b0;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk);
         #1;
         if (bus1.o_done) begin
            done_cnt++;
            if (done_edge < 0) begin
               done_edge = e;
               snap_amp  = bus1.o_amp_out;
               snap_idx  = bus1.o_result_idx;
               snap_ramp = bus1.o_result_amp;
            end
         end
      end
      ref_model(3, 0);
      chk("iter0_done_edge", 64'(done_edge), 64'd9);
      chk("iter0_done_count", 64'(done_cnt), 64'd1);
      chk("iter0_amps", snap_amp, m_packed);
      chk("iter0_idx", 64'(snap_idx), 64'd0);
      chk("iter0_amp", 64'(snap_ramp), 64'd23);

      // Stray start pulses while busy and in the DONE cycle.
      do_run(3'($urandom_range(7)), 1'b0, 1'b1);

      // Reset in the middle of a run.
      bus0.i_target = 3'd6;
      bus0.i_start  = 1'b1;
      @(posedge clk);
      #1;
      bus0.i_start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_busy", 64'(bus0.o_busy), 64'd0);
      chk("abort_amps", bus0.o_amp_out, 64'd0);
      chk("abort_idx", 64'(bus0.o_result_idx), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      done_cnt = 0;
      for (int e = 0; e < 20; e++) begin
         @(posedge clk);
         #1;
         if (bus0.o_done) done_cnt++;
      end
      chk("abort_no_done", 64'(done_cnt), 64'd0);
      do_run(3'd0, 1'b0, 1'b0);

      // Target sweep, then a few random targets.
      for (int t = 0; t < 8; t++) do_run(3'(t), 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) do_run(3'($urandom_range(7)), 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
